// File: rtl/hazard_bp_ctrl_pkg.sv
// Shared constants, types and helpers for the hazard / branch-prediction controller.
//   BHT_CNT_W  : width of one 2-bit saturating predictor counter
//   BHT_RESET  : counter value after reset (weakly not taken)
//   BHT_MIN/MAX: saturation limits of a predictor counter
//   hz_ctrl_t  : bundle of pipeline control strobes produced by the priority logic
package hazard_bp_ctrl_pkg;

   localparam int unsigned BHT_CNT_W = 2;

   localparam logic [BHT_CNT_W-1:0] BHT_RESET = 2'b01;
   localparam logic [BHT_CNT_W-1:0] BHT_MIN   = 2'b00;
   localparam logic [BHT_CNT_W-1:0] BHT_MAX   = 2'b11;

   typedef struct packed {
      logic stall_if;
      logic stall_id;
      logic flush_id;
      logic flush_ex;
      logic stall_lw;
      logic jr;
   } hz_ctrl_t;

   // Saturating step of one predictor counter toward the resolved outcome.
   function automatic logic [BHT_CNT_W-1:0] bht_next(input logic [BHT_CNT_W-1:0] cur,
                                                     input logic                 taken);
      logic [BHT_CNT_W-1:0] nxt;
      nxt = cur;
      if (taken) begin
         if (cur != BHT_MAX) nxt = cur + BHT_CNT_W'(1);
      end else begin
         if (cur != BHT_MIN) nxt = cur - BHT_CNT_W'(1);
      end
      return nxt;
   endfunction

endpackage

// File: rtl/hazard_bp_ctrl_bht_table.sv
// Branch history table: DEPTH 2-bit saturating counters.
//   clk, rst_n  : clock, async active-low reset (all entries -> BHT_RESET)
//   rd_idx      : lookup index; rd_taken is the MSB of that entry (combinational,
//                 so a same-cycle update at the same index is not yet visible)
//   wr_en       : train the entry at wr_idx toward wr_taken on the rising edge
module bht_table
   import hazard_bp_ctrl_pkg::*;
#(
   parameter int unsigned DEPTH = 16,
   parameter int unsigned IDX_W = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [IDX_W-1:0] rd_idx,
   output logic             rd_taken,
   input  logic             wr_en,
   input  logic [IDX_W-1:0] wr_idx,
   input  logic             wr_taken
);

   logic [BHT_CNT_W-1:0] tbl [DEPTH];

   // Prediction is the counter MSB: 2 and 3 mean taken.
   assign rd_taken = tbl[rd_idx][BHT_CNT_W-1];

   // Counter storage with saturating training.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tbl <= '{default: BHT_RESET};
      end else if (wr_en) begin
         tbl[wr_idx] <= bht_next(tbl[wr_idx], wr_taken);
      end
   end

endmodule

// File: rtl/hazard_bp_ctrl.sv
// Pipeline hazard controller with a 2-bit branch predictor.
//   clk_i, rst_n_i        : clock, async active-low reset
//   id_*                  : source registers / usage / JR flag of the ID instruction
//   ex_memread_i, ex_regdst_i : load-in-EX detection for load-use hazards
//   mem_busy_i            : shared RAM taken by MEM this cycle
//   if_pc_i, pred_taken_o : predictor lookup for the fetch PC
//   ex_isbranch_i, ex_pc_i, ex_taken_i, ex_pred_i : branch resolution / training
//   stall_*, flush_*, stall_LW_o, jr_o : pipeline control (combinational)
//   prewrong_o, precorrc_o: branch outcome vs prediction (combinational)
//   mispredict_cnt_o      : saturating count of mispredicts since reset
module hazard_bp_ctrl
   import hazard_bp_ctrl_pkg::*;
#(
   parameter int unsigned REG_W     = 4,
   parameter int unsigned PC_W      = 16,
   parameter int unsigned BHT_DEPTH = 16,
   parameter int unsigned CNT_W     = 16
) (
   input  logic             clk_i,
   input  logic             rst_n_i,
   input  logic [REG_W-1:0] id_regsrc1_i,
   input  logic [REG_W-1:0] id_regsrc2_i,
   input  logic             id_use1_i,
   input  logic             id_use2_i,
   input  logic             id_isjr_i,
   input  logic             ex_memread_i,
   input  logic [REG_W-1:0] ex_regdst_i,
   input  logic             mem_busy_i,
   input  logic [PC_W-1:0]  if_pc_i,
   input  logic             ex_isbranch_i,
   input  logic [PC_W-1:0]  ex_pc_i,
   input  logic             ex_taken_i,
   input  logic             ex_pred_i,
   output logic             pred_taken_o,
   output logic             stall_if_o,
   output logic             stall_id_o,
   output logic             flush_id_o,
   output logic             flush_ex_o,
   output logic             stall_LW_o,
   output logic             jr_o,
   output logic             prewrong_o,
   output logic             precorrc_o,
   output logic [CNT_W-1:0] mispredict_cnt_o
);

   localparam int unsigned    BHT_IDX_W = $clog2(BHT_DEPTH);
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic     mispred;
   logic     loaduse;
   logic     src1_hit;
   logic     src2_hit;
   hz_ctrl_t ctrl;
   logic [CNT_W-1:0] cnt_q;

   // Only the low PC bits index the table; upper bits intentionally alias.
   logic unused_pc_hi;
   assign unused_pc_hi = ^{if_pc_i, ex_pc_i};

   // Predictor storage, lookup and training.
   bht_table #(
      .DEPTH (BHT_DEPTH),
      .IDX_W (BHT_IDX_W)
   ) u_bht (
      .clk      (clk_i),
      .rst_n    (rst_n_i),
      .rd_idx   (if_pc_i[BHT_IDX_W-1:0]),
      .rd_taken (pred_taken_o),
      .wr_en    (ex_isbranch_i),
      .wr_idx   (ex_pc_i[BHT_IDX_W-1:0]),
      .wr_taken (ex_taken_i)
   );

   // Branch resolution against the prediction carried down the pipe.
   assign mispred    = ex_isbranch_i && (ex_taken_i != ex_pred_i);
   assign prewrong_o = mispred;
   assign precorrc_o = ex_isbranch_i && !mispred;

   // Load-use: JR reads regsrc1 as its target even without id_use1_i.
   assign src1_hit = (id_use1_i || id_isjr_i) && (ex_regdst_i == id_regsrc1_i);
   assign src2_hit = id_use2_i && (ex_regdst_i == id_regsrc2_i);
   assign loaduse  = ex_memread_i && (src1_hit || src2_hit);

   // Priority: mispredict > memory busy > load-use > JR redirect.
   // The load-use stall lasts one cycle because flush_ex pushes the load out of EX.
   always_comb begin
      ctrl = '0;
      if (mispred) begin
         ctrl.flush_id = 1'b1;
         ctrl.flush_ex = 1'b1;
      end else if (mem_busy_i) begin
         ctrl.stall_if = 1'b1;
         ctrl.stall_id = 1'b1;
         ctrl.flush_ex = 1'b1;
      end else if (loaduse) begin
         ctrl.stall_if = 1'b1;
         ctrl.stall_id = 1'b1;
         ctrl.flush_ex = 1'b1;
         ctrl.stall_lw = 1'b1;
      end else if (id_isjr_i) begin
         ctrl.jr       = 1'b1;
         ctrl.flush_id = 1'b1;
      end
   end

   assign stall_if_o = ctrl.stall_if;
   assign stall_id_o = ctrl.stall_id;
   assign flush_id_o = ctrl.flush_id;
   assign flush_ex_o = ctrl.flush_ex;
   assign stall_LW_o = ctrl.stall_lw;
   assign jr_o       = ctrl.jr;

   // Mispredict counter, saturating at all-ones.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else if (mispred && (cnt_q != CNT_MAX)) begin
         cnt_q <= cnt_q + CNT_W'(1);
      end
   end

   assign mispredict_cnt_o = cnt_q;

endmodule

// File: tb/tb_hazard_bp_ctrl.sv
// Self-checking bench for hazard_bp_ctrl: vector table, directed sequences and
// randomized cycles against a behavioural model.
module tb_hazard_bp_ctrl;

   localparam int unsigned REG_W = 4;
   localparam int unsigned PC_W  = 16;
   localparam int unsigned DEPTH = 16;

   logic             clk;
   logic             rst_n;
   logic [REG_W-1:0] id_regsrc1, id_regsrc2, ex_regdst;
   logic             id_use1, id_use2, id_isjr, ex_memread, mem_busy;
   logic [PC_W-1:0]  if_pc, ex_pc;
   logic             ex_isbranch, ex_taken, ex_pred;

   logic pred, stall_if, stall_id, flush_id, flush_ex, stall_lw, jr, prewrong, precorrc;
   logic [15:0] cnt;
   logic pred4, stall_if4, stall_id4, flush_id4, flush_ex4, stall_lw4, jr4, prewrong4, precorrc4;
   logic [3:0] cnt4;

   int checks   = 0;
   int failures = 0;

   int mdl_bht [DEPTH];
   int mdl_cnt;
   int mdl_cnt4;

   typedef struct {
      logic       isbr, tk, pr, busy, mr;
      logic [3:0] rd, s1, s2;
      logic       u1, u2, jr;
      logic [7:0] exp;   // {stall_if,stall_id,flush_id,flush_ex,stall_LW,jr,prewrong,precorrc}
   } vec_t;

   vec_t vt [14];

   hazard_bp_ctrl #(.REG_W(REG_W), .PC_W(PC_W), .BHT_DEPTH(DEPTH), .CNT_W(16)) dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .id_regsrc1_i(id_regsrc1), .id_regsrc2_i(id_regsrc2),
      .id_use1_i(id_use1), .id_use2_i(id_use2), .id_isjr_i(id_isjr),
      .ex_memread_i(ex_memread), .ex_regdst_i(ex_regdst), .mem_busy_i(mem_busy),
      .if_pc_i(if_pc), .ex_isbranch_i(ex_isbranch), .ex_pc_i(ex_pc),
      .ex_taken_i(ex_taken), .ex_pred_i(ex_pred),
      .pred_taken_o(pred), .stall_if_o(stall_if), .stall_id_o(stall_id),
      .flush_id_o(flush_id), .flush_ex_o(flush_ex), .stall_LW_o(stall_lw),
      .jr_o(jr), .prewrong_o(prewrong), .precorrc_o(precorrc),
      .mispredict_cnt_o(cnt));

   hazard_bp_ctrl #(.REG_W(REG_W), .PC_W(PC_W), .BHT_DEPTH(DEPTH), .CNT_W(4)) dut4 (
      .clk_i(clk), .rst_n_i(rst_n),
      .id_regsrc1_i(id_regsrc1), .id_regsrc2_i(id_regsrc2),
      .id_use1_i(id_use1), .id_use2_i(id_use2), .id_isjr_i(id_isjr),
      .ex_memread_i(ex_memread), .ex_regdst_i(ex_regdst), .mem_busy_i(mem_busy),
      .if_pc_i(if_pc), .ex_isbranch_i(ex_isbranch), .ex_pc_i(ex_pc),
      .ex_taken_i(ex_taken), .ex_pred_i(ex_pred),
      .pred_taken_o(pred4), .stall_if_o(stall_if4), .stall_id_o(stall_id4),
      .flush_id_o(flush_id4), .flush_ex_o(flush_ex4), .stall_LW_o(stall_lw4),
      .jr_o(jr4), .prewrong_o(prewrong4), .precorrc_o(precorrc4),
      .mispredict_cnt_o(cnt4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [7:0] act_ctrl();
      return {stall_if, stall_id, flush_id, flush_ex, stall_lw, jr, prewrong, precorrc};
   endfunction

   function automatic logic [7:0] act_ctrl4();
      return {stall_if4, stall_id4, flush_id4, flush_ex4, stall_lw4, jr4, prewrong4, precorrc4};
   endfunction

   // Expected control strobes from the priority rules.
   function automatic logic [7:0] mdl_ctrl();
      bit mp, lu, ok;
      mp = ex_isbranch && (ex_taken != ex_pred);
      ok = ex_isbranch && !mp;
      lu = ex_memread && ((((id_use1 || id_isjr) && (ex_regdst == id_regsrc1))) ||
                          (id_use2 && (ex_regdst == id_regsrc2)));
      if (mp)            return 8'b0011_0010;
      else if (mem_busy) return {7'b1101_000, ok};
      else if (lu)       return {7'b1101_100, ok};
      else if (id_isjr)  return {7'b0010_010, ok};
      else               return {7'b0000_000, ok};
   endfunction

   function automatic logic mdl_pred();
      return mdl_bht[int'(if_pc[3:0])] >= 2;
   endfunction

   task automatic mdl_reset();
      for (int i = 0; i < int'(DEPTH); i++) mdl_bht[i] = 1;
      mdl_cnt  = 0;
      mdl_cnt4 = 0;
   endtask

   // Compare all outputs with the model, advance one edge, update the model.
   task automatic tick();
      int idx;
      #1;
      chk("ctrl",  32'(act_ctrl()),  32'(mdl_ctrl()));
      chk("ctrl4", 32'(act_ctrl4()), 32'(mdl_ctrl()));
      chk("pred",  32'(pred),  32'(mdl_pred()));
      chk("pred4", 32'(pred4), 32'(mdl_pred()));
      chk("cnt",   32'(cnt),   mdl_cnt);
      chk("cnt4",  32'(cnt4),  mdl_cnt4);
      @(posedge clk);
      if (!rst_n) begin
         mdl_reset();
      end else begin
         if (ex_isbranch) begin
            idx = int'(ex_pc[3:0]);
            if (ex_taken) mdl_bht[idx] = (mdl_bht[idx] == 3) ? 3 : mdl_bht[idx] + 1;
            else          mdl_bht[idx] = (mdl_bht[idx] == 0) ? 0 : mdl_bht[idx] - 1;
         end
         if (ex_isbranch && (ex_taken != ex_pred)) begin
            if (mdl_cnt  < 65535) mdl_cnt++;
            if (mdl_cnt4 < 15)    mdl_cnt4++;
         end
      end
      #1;
   endtask

   task automatic clear_in();
      id_regsrc1 = '0; id_regsrc2 = '0; ex_regdst = '0;
      id_use1 = 0; id_use2 = 0; id_isjr = 0; ex_memread = 0; mem_busy = 0;
      if_pc = '0; ex_pc = '0; ex_isbranch = 0; ex_taken = 0; ex_pred = 0;
   endtask

   function automatic vec_t mk(input logic isbr, tk, pr, busy, mr,
                               input logic [3:0] rd, s1, s2,
                               input logic u1, u2, j, input logic [7:0] e);
      vec_t v;
      v.isbr = isbr; v.tk = tk; v.pr = pr; v.busy = busy; v.mr = mr;
      v.rd = rd; v.s1 = s1; v.s2 = s2; v.u1 = u1; v.u2 = u2; v.jr = j; v.exp = e;
      return v;
   endfunction

   task automatic drive_vec(input vec_t v);
      clear_in();
      ex_isbranch = v.isbr; ex_taken = v.tk; ex_pred = v.pr; mem_busy = v.busy;
      ex_memread = v.mr; ex_regdst = v.rd; id_regsrc1 = v.s1; id_regsrc2 = v.s2;
      id_use1 = v.u1; id_use2 = v.u2; id_isjr = v.jr;
   endtask

   initial begin
      logic [7:0] bht_seq;
      //        isbr tk pr bsy mr rd s1 s2 u1 u2 jr  expected
      vt[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0000);
      vt[1]  = mk(0, 0, 0, 0, 1, 3, 3, 0, 1, 0, 0, 8'b1101_1000);
      vt[2]  = mk(0, 0, 0, 0, 1, 3, 3, 0, 0, 0, 0, 8'b0000_0000);
      vt[3]  = mk(0, 0, 0, 0, 1, 5, 1, 5, 0, 1, 0, 8'b1101_1000);
      vt[4]  = mk(0, 0, 0, 0, 1, 0, 0, 2, 1, 1, 0, 8'b1101_1000);
      vt[5]  = mk(0, 0, 0, 0, 0, 7, 7, 0, 1, 0, 1, 8'b0010_0100);
      vt[6]  = mk(0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 1, 8'b1101_1000);
      vt[7]  = mk(0, 0, 0, 1, 0, 0, 1, 2, 1, 1, 0, 8'b1101_0000);
      vt[8]  = mk(0, 0, 0, 1, 1, 3, 3, 0, 1, 0, 1, 8'b1101_0000);
      vt[9]  = mk(1, 0, 1, 1, 1, 3, 3, 0, 1, 0, 0, 8'b0011_0010);
      vt[10] = mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 8'b0000_0001);
      vt[11] = mk(1, 0, 0, 0, 0, 0, 4, 0, 0, 0, 1, 8'b0010_0101);
      vt[12] = mk(1, 1, 0, 0, 1, 4, 4, 0, 1, 0, 1, 8'b0011_0010);
      vt[13] = mk(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8'b1101_0001);

      clear_in();
      rst_n = 1'b1;
      #1 rst_n = 1'b0;
      mdl_reset();
      #1;
      chk("rst_pred", 32'(pred), 0);
      chk("rst_cnt",  32'(cnt),  0);
      chk("rst_cnt4", 32'(cnt4), 0);
      // Combinational hazard logic keeps working while reset is held.
      ex_memread = 1; ex_regdst = 4'd3; id_regsrc1 = 4'd3; id_use1 = 1;
      #1 chk("rst_loaduse", 32'(act_ctrl()), 32'h0000_00d8);
      clear_in();
      @(posedge clk); @(posedge clk); #1;
      rst_n = 1'b1;

      // Vector table.
      for (int i = 0; i < 14; i++) begin
         drive_vec(vt[i]);
         #1 chk($sformatf("vec%0d", i), 32'(act_ctrl()), 32'(vt[i].exp));
         tick();
      end

      // Load-use releases once the load has left EX.
      clear_in();
      ex_memread = 1; ex_regdst = 4'd3; id_regsrc1 = 4'd3; id_use1 = 1;
      #1 chk("lu_on", 32'({stall_lw, stall_if, stall_id, flush_ex}), 32'hf);
      tick();
      ex_memread = 0;
      #1 chk("lu_off", 32'({stall_lw, stall_if, stall_id, flush_ex}), 32'h0);
      tick();

      // Training with aliasing lookup; same-cycle update not visible.
      rst_n = 1'b0; #1 mdl_reset(); rst_n = 1'b1;
      clear_in();
      if_pc = 16'h0015; ex_pc = 16'h0005; ex_isbranch = 1; ex_taken = 1; ex_pred = 1;
      #1 chk("bht_pre", 32'(pred), 0);
      bht_seq = 8'b1111_1000;
      for (int k = 0; k < 8; k++) begin
         ex_taken = (k < 4);
         ex_pred  = ex_taken;
         tick();
         chk($sformatf("bht_e%0d", k), 32'(pred), 32'(bht_seq[7-k]));
      end

      // Memory busy holds a JR until it clears.
      clear_in();
      id_isjr = 1; id_regsrc1 = 4'd6; mem_busy = 1;
      for (int k = 0; k < 3; k++) begin
         #1 chk($sformatf("busy_jr%0d", k), 32'({stall_if, stall_id, flush_ex, jr}), 32'he);
         tick();
      end
      mem_busy = 0;
      #1 chk("jr_go", 32'({jr, flush_id, stall_if}), 32'h6);
      tick();

      // 17 mispredicts saturate the narrow counter.
      clear_in();
      ex_isbranch = 1; ex_pred = 1; ex_taken = 0; ex_pc = 16'h0009;
      for (int k = 0; k < 17; k++) tick();
      chk("cnt4_sat", 32'(cnt4), 15);

      // Train, then reset between edges.
      clear_in();
      if_pc = 16'h0005; ex_pc = 16'h0005; ex_isbranch = 1; ex_taken = 1; ex_pred = 1;
      for (int k = 0; k < 3; k++) tick();
      ex_isbranch = 0;
      #1 chk("trained_pred", 32'(pred), 1);
      rst_n = 1'b0;
      #1;
      chk("async_pred", 32'(pred), 0);
      chk("async_cnt",  32'(cnt),  0);
      chk("async_cnt4", 32'(cnt4), 0);
      mdl_reset();
      rst_n = 1'b1;
      #1 chk("post_rst_pred", 32'(pred), 0);
      tick();

      // Randomized cycles against the model.
      for (int n = 0; n < 400; n++) begin
         id_regsrc1  = 4'($urandom_range(0, 3));
         id_regsrc2  = 4'($urandom_range(0, 3));
         ex_regdst   = 4'($urandom_range(0, 3));
         id_use1     = 1'($urandom);
         id_use2     = 1'($urandom);
         id_isjr     = ($urandom_range(0, 3) == 0);
         ex_memread  = 1'($urandom);
         mem_busy    = ($urandom_range(0, 4) == 0);
         if_pc       = 16'($urandom);
         ex_pc       = ($urandom_range(0, 1) == 0) ? if_pc : 16'($urandom);
         ex_isbranch = 1'($urandom);
         ex_taken    = 1'($urandom);
         ex_pred     = ($urandom_range(0, 3) == 0) ? ~ex_taken : ex_taken;
         tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/hazard_bp_ctrl.md
HAZARD_BP_CTRL -- requirements
Module: hazard_bp_ctrl

Interface
REQ-001 Parameter REG_W, default 4, register-index width.
REQ-002 Parameter PC_W, default 16, program-counter width.
REQ-003 Parameter BHT_DEPTH, default 16, predictor entries, power of two >= 2; BHT_IDX_W = log2(BHT_DEPTH).
REQ-004 Parameter CNT_W, default 16, mispredict-counter width.
REQ-005 clk_i  in  1  single clock; all state updates on rising edge.
REQ-006 rst_n_i  in  1  asynchronous, active-low reset.
REQ-007 id_regsrc1_i / id_regsrc2_i  in  REG_W  source registers of the instruction in ID.
REQ-008 id_use1_i / id_use2_i  in  1  the matching source is actually read.
REQ-009 id_isjr_i  in  1  ID holds JR; target register is id_regsrc1_i.
REQ-010 ex_memread_i  in  1  EX holds a load.
REQ-011 ex_regdst_i  in  REG_W  destination register of the EX instruction.
REQ-012 mem_busy_i  in  1  shared instruction/data RAM occupied by MEM this cycle.
REQ-013 if_pc_i  in  PC_W  fetch PC, used for prediction lookup.
REQ-014 ex_isbranch_i  in  1  EX holds a conditional branch.
REQ-015 ex_pc_i  in  PC_W  PC of the EX branch.
REQ-016 ex_taken_i / ex_pred_i  in  1  actual outcome / prediction carried with the branch.
REQ-017 pred_taken_o  out  1  prediction for if_pc_i.
REQ-018 stall_if_o / stall_id_o  out  1  hold PC / hold IF-ID register.
REQ-019 flush_id_o / flush_ex_o  out  1  bubble into IF-ID / ID-EX.
REQ-020 stall_LW_o  out  1  load-use stall active.
REQ-021 jr_o  out  1  JR redirect taken this cycle.
REQ-022 prewrong_o / precorrc_o  out  1  EX branch mispredicted / predicted correctly.
REQ-023 mispredict_cnt_o  out  CNT_W  count of mispredicts since reset.

Function
REQ-024 Index = PC[BHT_IDX_W-1:0]; table holds BHT_DEPTH 2-bit saturating counters; pred_taken_o = MSB of entry at if_pc_i index, combinational.
REQ-025 On ex_isbranch_i at a clock edge, entry at ex_pc_i index increments if ex_taken_i (saturate at 3), else decrements (saturate at 0).
REQ-026 Lookup and update at same index in same cycle: pred_taken_o reflects pre-update value; update visible next cycle.
REQ-027 loaduse = ex_memread_i and ex_regdst_i equals a used ID source (id_use1_i/id_use2_i, or id_isjr_i on regsrc1); no register index is exempt.
REQ-028 mispred = ex_isbranch_i and ex_taken_i != ex_pred_i; prewrong_o = mispred; precorrc_o = ex_isbranch_i and not mispred; combinational.
REQ-029 Priority, highest first: mispred, mem_busy_i, loaduse, JR.
REQ-030 mispred: flush_id_o=1, flush_ex_o=1, stalls 0, jr_o=0, regardless of other inputs.
REQ-031 mem_busy_i (no mispred): stall_if_o=stall_id_o=1, flush_ex_o=1 for every busy cycle, stall_LW_o=0, jr_o=0.
REQ-032 loaduse (neither above): stall_if_o=stall_id_o=1, flush_ex_o=1, stall_LW_o=1 for exactly one cycle, released once the load leaves EX.
REQ-033 id_isjr_i with no higher condition: jr_o=1, flush_id_o=1 for one cycle.
REQ-034 No condition: all control outputs 0.
REQ-035 mispredict_cnt_o increments by 1 per edge with mispred, saturating at all-ones (no wrap).

Reset
REQ-036 rst_n_i low: all BHT entries to 2'b01 (weakly not taken), mispredict_cnt_o to 0, immediately and asynchronously.
REQ-037 While in reset pred_taken_o=0; combinational outputs follow inputs per REQ-027..034.
REQ-038 Reset asserted mid-operation discards all training; first post-reset lookup returns 0.

Structure
REQ-039 Shared package holds BHT reset value 2'b01 and saturation limits 0/3.
REQ-040 One sub-module bht_table (storage, lookup, saturating update); priority logic and counter in top.

Verification
REQ-041 ex_memread_i=1, ex_regdst_i=3, id_regsrc1_i=3, id_use1_i=1 -> stall_LW_o, stall_if_o, stall_id_o, flush_ex_o =1 one cycle; 0 after ex_memread_i drops.
REQ-042 Reset, four edges of branch at PC 0x0005 taken -> pred_taken_o for PC 0x0015 (alias) goes 1 after first update, entry saturates at 3; four not-taken -> back to 0.
REQ-043 ex_isbranch_i=1, ex_pred_i=1, ex_taken_i=0 with mem_busy_i=1 and loaduse true -> prewrong_o=1, flush_id_o=flush_ex_o=1, stalls 0, mispredict_cnt_o +1.
REQ-044 mem_busy_i=1 three cycles with id_isjr_i=1 -> stall held 3 cycles, jr_o=0; cycle 4 jr_o=1, flush_id_o=1.
REQ-045 CNT_W=4, 17 mispredicts -> mispredict_cnt_o stays 15.
REQ-046 Assert rst_n_i low between clock edges after training -> counter 0 and pred_taken_o 0 without waiting for an edge.
